uart_rx: RTL

Serial receive front end of the UART-to-AXI bridge. Oversamples the asynchronous `rx` line at 16x the baud rate and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit. Each good byte is pushed into the downstream receive FIFO through its `wr`/`w_data` write port, and framing and overrun errors are flagged. Sits directly upstream of the receive FIFO, which feeds the command parser.

---
 rtl/uart_pkg.sv | 17 +
 rtl/baud_tick_gen.sv | 33 +++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
package uart_pkg;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;
  localparam int         DEFAULT_DIV = 27;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by clear.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Free-running divider; clear realigns the phase to the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling, FIFO write port and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV    = DEFAULT_DIV,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DWIDTH-1:0] fifo_wdata,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int            SCW      = $clog2(OVERSAMPLE);
  localparam int            BW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

  rx_state_e         state;
  rx_state_e         next_state;
  logic              rx_meta;
  logic              rx_s;
  logic              tick;
  logic              tick_clear;
  logic [SCW-1:0]    sc;
  logic [BW-1:0]     bit_idx;
  logic [DWIDTH-1:0] shreg;
  logic              mid_tick;
  logic              last_tick;
  logic              wr_next;
  logic              ovr_next;
  logic              ferr_next;
  logic              busy_next;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick_clear = (state == ST_IDLE) && !rx_s;
  assign mid_tick   = tick && (sc == MID_SAMPLE);
  assign last_tick  = tick && (sc == LAST_SAMPLE);

  baud_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) next_state = ST_START;
        else       next_state = ST_IDLE;
      end
      ST_START: begin
        if (mid_tick) next_state = rx_s ? ST_IDLE : ST_DATA;
        else          next_state = ST_START;
      end
      ST_DATA: begin
        if (last_tick && (bit_idx == LAST_BIT)) next_state = ST_STOP;
        else                                    next_state = ST_DATA;
      end
      ST_STOP: begin
        if (last_tick) next_state = rx_s ? ST_IDLE : ST_WAIT_HIGH;
        else           next_state = ST_STOP;
      end
      ST_WAIT_HIGH: begin
        if (rx_s) next_state = ST_IDLE;
        else      next_state = ST_WAIT_HIGH;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM output decode: stop-bit decision becomes next-cycle pulses.
  always_comb begin
    wr_next   = 1'b0;
    ovr_next  = 1'b0;
    ferr_next = 1'b0;
    busy_next = (next_state != ST_IDLE);
    if ((state == ST_STOP) && last_tick) begin
      if (!rx_s) begin
        ferr_next = 1'b1;
      end else if (fifo_full) begin
        ovr_next = 1'b1;
      end else begin
        wr_next = 1'b1;
      end
    end else begin
      wr_next   = 1'b0;
      ovr_next  = 1'b0;
      ferr_next = 1'b0;
    end
  end

  // Sample counter, bit index and shift register; sc wraps naturally between bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (tick_clear) begin
      sc      <= '0;
      bit_idx <= '0;
    end else if ((state == ST_START) && mid_tick) begin
      sc      <= '0;
      bit_idx <= '0;
    end else if ((state == ST_DATA) && last_tick) begin
      sc      <= sc + SCW'(1);
      bit_idx <= bit_idx + BW'(1);
      shreg   <= {rx_s, shreg[DWIDTH-1:1]};
    end else if ((state != ST_IDLE) && tick) begin
      sc <= sc + SCW'(1);
    end else begin
      sc <= sc;
    end
  end

  // Registered outputs; write data holds its value between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wr    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wr   <= wr_next;
      frame_err <= ferr_next;
      overrun   <= ovr_next;
      busy      <= busy_next;
      if (wr_next) begin
        fifo_wdata <= shreg;
      end else begin
        fifo_wdata <= fifo_wdata;
      end
    end
  end

endmodule
